hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the ID/EX pipeline register and the surrounding IF/ID and PC stages.
- Decides each cycle whether the instruction in ID advances, is replaced by a bubble, or is held.
- Covers three hazard sources: load-use hazards, taken-branch flushes, and multi-cycle EX operations (mult/div).
- Contains a registered FSM and a latency counter; the front-end write-enable and flush signals are decoded from the FSM state plus the current hazard inputs.

Parameters:
- MULDIV_LATENCY, 4, number of EX cycles a multi-cycle op occupies (legal range 1..16; 1 = never enters MD_BUSY).

Ports:
- Clk  in  1  pipeline clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads rt as a source.
- ID_MultiCycle  in  1  the ID instruction is a mult/div.
- EX_MemRead  in  1  the instruction in EX is a load.
- EX_Rt  in  5  destination rt of the instruction in EX.
- EX_BranchTaken  in  1  a branch resolved taken in EX this cycle.
- ExtStall  in  1  external freeze request (memory wait).
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID register load enable.
- IF_ID_Flush  out  1  zero the IF/ID instruction.
- ID_EX_Bubble  out  1  force all ID/EX control bits (RegWrite, MemWrite, MemRead, Branch, MemToReg) to 0 on the next edge.
- ID_EX_Hold  out  1  ID/EX register retains its contents.
- Busy  out  1  FSM is in MD_BUSY.

Behaviour:
- States: RUN and MD_BUSY. Counter MdCnt is 4 bits wide.
- Reset (asynchronous): state=RUN, MdCnt=0. While Reset is high, outputs are forced to:
  - PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, ID_EX_Hold=0, Busy=0.
- Load-use hazard (LU) is true when all of the following hold:
  - EX_MemRead=1 and EX_Rt!=0, and
  - EX_Rt==ID_Rs, or (ID_UsesRt=1 and EX_Rt==ID_Rt).
- Defaults: PCWrite=1, IF_ID_Write=1, all other outputs 0.
- Priority in every state: ExtStall first.
  - ExtStall=1 gives PCWrite=0, IF_ID_Write=0, ID_EX_Hold=1, Bubble=0, Flush=0.
  - State and MdCnt are frozen; branch, LU and multi-cycle inputs are ignored that cycle.
- RUN, evaluated in priority order:
  1. EX_BranchTaken=1: IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1 (target loaded). ID_MultiCycle and LU are ignored because the ID instruction is killed. Next state RUN.
  2. LU=1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. Exactly one bubble is inserted, since the next cycle EX holds the bubble. Next state RUN. A mult/div with LU waits and is re-evaluated next cycle.
  3. ID_MultiCycle=1 and MULDIV_LATENCY>1: the op issues normally this cycle. Next state MD_BUSY, MdCnt=MULDIV_LATENCY-1.
  4. Otherwise: normal advance, stay in RUN.
- MD_BUSY:
  - Outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Hold=1, Busy=1.
  - MdCnt decrements each cycle. When MdCnt==1 and ExtStall=0, next state is RUN and MdCnt=0.
  - EX_BranchTaken and LU are ignored, since EX holds a mult/div.
  - Total EX occupancy is MULDIV_LATENCY cycles: 1 issue-follow cycle in RUN plus MULDIV_LATENCY-1 cycles in MD_BUSY.
- ID_EX_Bubble and ID_EX_Hold are never both 1.
- Reset asserted mid-MD_BUSY aborts immediately to RUN.
- Back-to-back mult/div: the second one is seen in RUN on the exit cycle and re-enters MD_BUSY.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - StallCycles (out, 32): counts cycles with PCWrite=0 and Reset=0.
  - FlushCount (out, 32): counts cycles with IF_ID_Flush=1 and Reset=0.
  - Both are saturating at 32'hFFFFFFFF and asynchronously reset to 0.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rt=5, ID_Rs=5 → exactly 1 cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. With EX_Rt=0 instead → no stall.
- rt-only match: EX_Rt=7, ID_Rt=7, ID_UsesRt=0 → no stall. Same with ID_UsesRt=1 → 1-cycle stall.
- Branch: EX_BranchTaken=1 together with an LU condition → IF_ID_Flush=1, Bubble=1, PCWrite=1, no stall cycle.
- Mult/div, MULDIV_LATENCY=4: ID_MultiCycle=1 for one cycle → Busy=1 and ID_EX_Hold=1 for exactly 3 cycles, then RUN. With ExtStall=1 for 2 cycles mid-busy → Busy lasts 5 cycles.
- Reset asserted asynchronously between edges while in MD_BUSY with MdCnt=2 → outputs immediately take their reset values; after deassertion, state is RUN and Busy=0.
- With HAZARD_PERF_CNT_EN: run 1 LU stall, 1 branch, and 1 mult with MULDIV_LATENCY=4 → StallCycles=4, FlushCount=1.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall control bundle between the ID-stage decode and the sequencing controller.
// Optional perf counter signals appear when HAZARD_PERF_CNT_EN is defined.
interface hazard_stall_controller_if;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRt;
  logic        ID_MultiCycle;
  logic        EX_MemRead;
  logic [4:0]  EX_Rt;
  logic        EX_BranchTaken;
  logic        ExtStall;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Bubble;
  logic        ID_EX_Hold;
  logic        Busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles;
  logic [31:0] FlushCount;
`endif

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_MultiCycle, EX_MemRead, EX_Rt,
           EX_BranchTaken, ExtStall,
`ifdef HAZARD_PERF_CNT_EN
    input  StallCycles, FlushCount,
`endif
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Hold, Busy
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_MultiCycle, EX_MemRead, EX_Rt,
           EX_BranchTaken, ExtStall,
`ifdef HAZARD_PERF_CNT_EN
    output StallCycles, FlushCount,
`endif
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Hold, Busy
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// ID/EX sequencing controller: load-use stalls, taken-branch flushes, mult/div occupancy.
// Define HAZARD_PERF_CNT_EN to add saturating StallCycles/FlushCount counters.
module hazard_stall_controller #(
  parameter int MULDIV_LATENCY = 4
) (
  input logic                       Clk,
  input logic                       Reset,
  hazard_stall_controller_if.slave  bus
);
  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam bit         MD_EN   = (MULDIV_LATENCY > 1);
  localparam logic [3:0] MD_LOAD = 4'(MULDIV_LATENCY - 1);

  state_t     state;
  logic [3:0] md_cnt;
  logic       lu;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, busy;

  assign lu = bus.EX_MemRead && (bus.EX_Rt != 5'd0) &&
              ((bus.EX_Rt == bus.ID_Rs) || (bus.ID_UsesRt && (bus.EX_Rt == bus.ID_Rt)));

  // ExtStall freezes everything; a branch kills the ID mult/div before it can issue.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= RUN;
      md_cnt <= '0;
    end else if (!bus.ExtStall) begin
      case (state)
        RUN: begin
          if (!bus.EX_BranchTaken && !lu && bus.ID_MultiCycle && MD_EN) begin
            state  <= MD_BUSY;
            md_cnt <= MD_LOAD;
          end
        end
        MD_BUSY: begin
          if (md_cnt <= 4'd1) begin
            state  <= RUN;
            md_cnt <= '0;
          end else begin
            md_cnt <= md_cnt - 4'd1;
          end
        end
        default: begin
          state  <= RUN;
          md_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    busy        = (state == MD_BUSY);
    if (Reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      busy        = 1'b0;
    end else if (bus.ExtStall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_hold  = 1'b1;
    end else if (state == MD_BUSY) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_hold  = 1'b1;
    end else if (bus.EX_BranchTaken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign bus.PCWrite      = pc_write;
  assign bus.IF_ID_Write  = ifid_write;
  assign bus.IF_ID_Flush  = ifid_flush;
  assign bus.ID_EX_Bubble = idex_bubble;
  assign bus.ID_EX_Hold   = idex_hold;
  assign bus.Busy         = busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
      if (ifid_flush && (flush_count != 32'hFFFF_FFFF)) flush_count <= flush_count + 32'd1;
    end
  end

  assign bus.StallCycles = stall_cycles;
  assign bus.FlushCount  = flush_count;
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: stimulus pushes hand-computed output vectors, a negedge monitor compares.
module tb_hazard_stall_controller;
  logic Clk = 1'b0;
  logic Reset;

  hazard_stall_controller_if bus ();

  hazard_stall_controller #(.MULDIV_LATENCY(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Hold, Busy}
  localparam logic [5:0] RST  = 6'b001100;
  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] LUS  = 6'b000100;
  localparam logic [5:0] BR   = 6'b111100;
  localparam logic [5:0] EXT  = 6'b000010;
  localparam logic [5:0] BUSY = 6'b000011;

  typedef struct {
    string      nm;
    logic [5:0] v;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic mc, input logic mr, input logic [4:0] ert,
                       input logic br, input logic ext);
    bus.ID_Rs          = rs;
    bus.ID_Rt          = rt;
    bus.ID_UsesRt      = ur;
    bus.ID_MultiCycle  = mc;
    bus.EX_MemRead     = mr;
    bus.EX_Rt          = ert;
    bus.EX_BranchTaken = br;
    bus.ExtStall       = ext;
  endtask

  task automatic cyc(input string nm, input logic rst, input logic [4:0] rs,
                     input logic [4:0] rt, input logic ur, input logic mc, input logic mr,
                     input logic [4:0] ert, input logic br, input logic ext,
                     input logic [5:0] e);
    exp_t x;
    @(posedge Clk);
    #1;
    Reset = rst;
    drive(rs, rt, ur, mc, mr, ert, br, ext);
    x.nm = nm;
    x.v  = e;
    q.push_back(x);
  endtask

  task automatic idle(input string nm, input logic [5:0] e);
    cyc(nm, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, e);
  endtask

  initial begin : monitor
    exp_t       x;
    logic [5:0] got;
    forever begin
      @(negedge Clk);
      if (q.size() > 0) begin
        x   = q.pop_front();
        got = {bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush,
               bus.ID_EX_Bubble, bus.ID_EX_Hold, bus.Busy};
        n_tests++;
        if (got !== x.v) begin
          n_fail++;
          $display("FAIL %s: got %b want %b", x.nm, got, x.v);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t x;
    int   waited;
    Reset = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    //   name        rst  rs     rt     ur    mc    mr    ert    br    ext   exp
    cyc("reset",     1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, RST);
    idle("idle0", NORM);
    cyc("lu_rs",     0, 5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, LUS);
    cyc("lu_after",  0, 5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, NORM);
    cyc("lu_rt0",    0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, NORM);
    cyc("rt_nouse",  0, 5'd1,  5'd7,  1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, NORM);
    cyc("rt_use",    0, 5'd1,  5'd7,  1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, LUS);
    cyc("br_lu_mc",  0, 5'd5,  5'd0,  1'b0, 1'b1, 1'b1, 5'd5,  1'b1, 1'b0, BR);
    idle("br_after", NORM);
    cyc("ext_run",   0, 5'd5,  5'd0,  1'b0, 1'b1, 1'b1, 5'd5,  1'b1, 1'b1, EXT);
    idle("ext_after", NORM);
    cyc("lu_mc",     0, 5'd5,  5'd0,  1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, LUS);
    cyc("mc_issue",  0, 5'd5,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, NORM);
    cyc("busy3_br",  0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, BUSY);
    cyc("busy2_lu",  0, 5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, BUSY);
    idle("busy1", BUSY);
    idle("md_exit", NORM);

    // ExtStall for two cycles inside MD_BUSY stretches Busy to 5 cycles
    cyc("mc_issue2", 0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, NORM);
    idle("eb_busy3", BUSY);
    cyc("eb_ext1",   0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, BUSY);
    cyc("eb_ext2",   0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, BUSY);
    idle("eb_busy2", BUSY);
    idle("eb_busy1", BUSY);
    idle("eb_exit", NORM);

    // back-to-back mult/div: second one held in ID, re-issues on exit cycle
    cyc("bb_issue",  0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, NORM);
    cyc("bb_b3",     0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, BUSY);
    cyc("bb_b2",     0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, BUSY);
    cyc("bb_b1",     0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, BUSY);
    cyc("bb_reissue",0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, NORM);
    idle("bb2_b3", BUSY);
    idle("bb2_b2", BUSY);
    idle("bb2_b1", BUSY);
    idle("bb2_exit", NORM);

    // asynchronous reset between edges while MdCnt==2
    cyc("ar_issue",  0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, NORM);
    idle("ar_busy3", BUSY);
    @(posedge Clk);
    #1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    Reset = 1'b1;
    x.nm = "async_rst";
    x.v  = RST;
    q.push_back(x);
    cyc("ar_hold",   1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, RST);
    idle("ar_release", NORM);
    idle("ar_run", NORM);

    // perf scenario: 1 LU stall, 1 branch, 1 mult (3 busy cycles)
    cyc("pf_reset",  1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, RST);
    cyc("pf_lu",     0, 5'd3,  5'd0,  1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, LUS);
    idle("pf_idle", NORM);
    cyc("pf_br",     0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, BR);
    cyc("pf_mc",     0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, NORM);
    idle("pf_b3", BUSY);
    idle("pf_b2", BUSY);
    idle("pf_b1", BUSY);
    idle("pf_exit", NORM);

    @(posedge Clk);
    #1;
`ifdef HAZARD_PERF_CNT_EN
    n_tests++;
    if (bus.StallCycles !== 32'd4) begin
      n_fail++;
      $display("FAIL stall_cycles: got %0d want 4", bus.StallCycles);
    end
    n_tests++;
    if (bus.FlushCount !== 32'd1) begin
      n_fail++;
      $display("FAIL flush_count: got %0d want 1", bus.FlushCount);
    end
`endif

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge Clk);
      waited++;
    end
    #1;
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
